// File: rtl/link_rx.sv
// link_rx: credit-flow link receiver with a first-word fall-through buffer; LINK_RX_ERR_CNT_EN enables err_count
module link_rx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             link_valid,
  input  logic [WIDTH-1:0] link_data,
  input  logic             link_error,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       credit_ret,
  output logic             overflow,
  output logic [7:0]       err_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic good, bad, full, pop, push;
  assign good = link_valid & ~link_error;
  assign bad = link_valid & link_error;
  assign full = count == (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign out_data = mem[rd_ptr];
  assign pop = out_valid & out_ready;
  // a full buffer still takes a word when the head leaves on the same edge
  assign push = good & (~full | pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      credit_ret <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      credit_ret <= {1'b0, pop} + {1'b0, bad};
      if (good & full & ~pop) overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= link_data;
`ifdef LINK_RX_ERR_CNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= '0;
    else if (bad && err_q != 8'hFF) err_q <= err_q + 8'd1;
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_link_rx.sv
// tb_link_rx: directed scoreboard bench for link_rx
module tb_link_rx;
  logic clk = 1'b0, rst_n = 1'b0;
  logic link_valid = 1'b0, link_error = 1'b0, out_ready = 1'b0;
  logic [31:0] link_data = '0;
  logic out_valid, overflow;
  logic [31:0] out_data;
  logic [1:0] credit_ret;
  logic [7:0] err_count;
  int errors = 0, checks = 0, credit_total = 0;
  logic [31:0] q[$];
`ifdef LINK_RX_ERR_CNT_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif

  link_rx dut (
    .clk(clk), .rst_n(rst_n), .link_valid(link_valid), .link_data(link_data),
    .link_error(link_error), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .credit_ret(credit_ret), .overflow(overflow),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a pop happens on the next rising edge
  always @(negedge clk)
    if (rst_n) begin
      credit_total += int'(credit_ret);
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %0h expected none", out_data);
        end else begin
          logic [31:0] e;
          e = q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %0h expected %0h", out_data, e);
          end
        end
      end
    end

  task automatic drive(input logic v, input logic er, input logic [31:0] d);
    link_valid = v;
    link_error = er;
    link_data = d;
    @(posedge clk);
    #1;
    link_valid = 1'b0;
    link_error = 1'b0;
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_credit", 32'(credit_ret), 0);
    check("rst_err_count", 32'(err_count), 0);
    #2 rst_n = 1'b1;
    #1 check("post_rst_empty", 32'(out_valid), 0);
  endtask

  initial begin
    #2;
    check("init_out_valid", 32'(out_valid), 0);
    check("init_credit", 32'(credit_ret), 0);
    check("init_overflow", 32'(overflow), 0);
    check("init_err_count", 32'(err_count), 0);
    #5 rst_n = 1'b1;
    // streaming with consumer ready
    out_ready = 1'b1;
    q.push_back(32'hA1); q.push_back(32'hA2); q.push_back(32'hA3);
    drive(1, 0, 32'hA1);
    check("s_valid1", 32'(out_valid), 1);
    check("s_data1", out_data, 32'hA1);
    check("s_credit1", 32'(credit_ret), 0);
    drive(1, 0, 32'hA2);
    check("s_data2", out_data, 32'hA2);
    check("s_credit2", 32'(credit_ret), 1);
    drive(1, 0, 32'hA3);
    check("s_data3", out_data, 32'hA3);
    check("s_credit3", 32'(credit_ret), 1);
    drive(0, 0, 0);
    check("s_credit4", 32'(credit_ret), 1);
    check("s_empty", 32'(out_valid), 0);
    drive(0, 0, 0);
    check("s_credit5", 32'(credit_ret), 0);
    // overflow with stalled consumer
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) q.push_back(32'h10 + 32'(i));
      drive(1, 0, 32'h10 + 32'(i));
      check("o_credit", 32'(credit_ret), 0);
      check("o_overflow", 32'(overflow), i == 4 ? 1 : 0);
    end
    check("o_head", out_data, 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive(0, 0, 0);
    check("o_drained", q.size(), 0);
    check("o_empty", 32'(out_valid), 0);
    check("o_sticky", 32'(overflow), 1);
    // full buffer push with simultaneous pop
    reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(32'h20 + 32'(i));
      drive(1, 0, 32'h20 + 32'(i));
    end
    out_ready = 1'b1;
    q.push_back(32'h55);
    drive(1, 0, 32'h55);
    check("f_overflow", 32'(overflow), 0);
    check("f_credit", 32'(credit_ret), 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0);
    check("f_drained", q.size(), 0);
    check("f_overflow_end", 32'(overflow), 0);
    // errored word alongside a pop
    out_ready = 1'b0;
    q.push_back(32'h30);
    drive(1, 0, 32'h30);
    out_ready = 1'b1;
    drive(1, 1, 32'hEE);
    check("e_credit", 32'(credit_ret), 2);
    check("e_err_count", 32'(err_count), EC ? 1 : 0);
    check("e_empty", 32'(out_valid), 0);
    drive(0, 0, 0);
    check("e_credit_after", 32'(credit_ret), 0);
    // err_count saturation and credit totals
    reset_mid();
    out_ready = 1'b0;
    credit_total = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, 32'hBAD0 + 32'(i));
      if (i == 254) check("c_err255", 32'(err_count), EC ? 255 : 0);
    end
    drive(0, 0, 0);
    check("c_err300", 32'(err_count), EC ? 255 : 0);
    check("c_credits", credit_total, 300);
    check("c_empty", 32'(out_valid), 0);
    // reset between edges with words buffered
    for (int i = 0; i < 5; i++) begin
      if (i < 4) q.push_back(32'h40 + 32'(i));
      drive(1, 0, 32'h40 + 32'(i));
    end
    check("r_overflow", 32'(overflow), 1);
    out_ready = 1'b1;
    drive(0, 0, 0);
    out_ready = 1'b0;
    check("r_head", out_data, 32'h41);
    reset_mid();
    q.push_back(32'h77);
    drive(1, 0, 32'h77);
    check("r_first_push", 32'(out_valid), 1);
    check("r_first_data", out_data, 32'h77);
    out_ready = 1'b1;
    drive(0, 0, 0);
    check("r_drained", q.size(), 0);
    check("r_empty", 32'(out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/link_rx.md
LINK_RX -- requirements
Module: link_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: receive buffer entries; power of two, range 2..64.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port link_valid, input, 1 bit: a word is present on the link this cycle.
REQ-006 SHALL have port link_data, input, WIDTH bits: link payload.
REQ-007 SHALL have port link_error, input, 1 bit: the word on the link this cycle is corrupted.
REQ-008 SHALL have port out_valid, output, 1 bit: the buffer head is valid.
REQ-009 SHALL have port out_data, output, WIDTH bits: the buffer head payload.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the head.
REQ-011 SHALL have port credit_ret, output, 2 bits: credits returned to the transmitter this cycle (0..2).
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag set when a good word is dropped because the buffer is full.
REQ-013 SHALL have port err_count, output, 8 bits: count of link words received with link_error set.

Function
REQ-014 SHALL be the receiving end of a credit-flow link with no backpressure; the transmitter holds DEPTH credits after reset.
REQ-015 SHALL treat a word as good when link_valid=1 and link_error=0, and push it into a DEPTH-entry FIFO at the clock edge.
REQ-016 SHALL discard the payload when link_valid=1 and link_error=1, and SHALL still return that word's credit.
REQ-017 SHALL ignore link_error and link_data when link_valid=0.
REQ-018 SHALL present the FIFO head combinationally from storage (first-word fall-through): a good word received at edge N gives out_valid=1 in cycle N+1.
REQ-019 SHALL pop the head on a clock edge where out_valid=1 and out_ready=1; out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-020 SHALL drive out_valid=0 when the FIFO is empty; out_data is don't-care while out_valid=0.
REQ-021 SHALL, when the FIFO is full, still accept a push on an edge where a pop also occurs; the occupancy is unchanged.
REQ-022 SHALL, when the FIFO is full and no pop occurs, drop the good word, leave the FIFO unchanged, and set overflow to 1 until reset.
REQ-023 SHALL return no credit for a word dropped under REQ-022.
REQ-024 SHALL register credit_ret, equal to (number of pops at edge N) + (number of errored words at edge N), visible in cycle N+1, with a value range of 0..2.
REQ-025 SHALL let read and write pointers wrap modulo DEPTH, and SHALL track occupancy with a log2(DEPTH)+1 bit counter.
REQ-026 SHALL saturate err_count at 255 and never wrap it.

Reset
REQ-027 SHALL, while rst_n=0, clear the pointers and occupancy and drive out_valid=0, credit_ret=0, overflow=0 and err_count=0, without waiting for a clock edge.
REQ-028 SHALL, on reset asserted mid-operation, discard buffered words and pending credits; the transmitter is reset together with the receiver.
REQ-029 SHALL release reset synchronously, with the first push possible at the first clock edge where rst_n=1.

Configuration
REQ-030 SHALL, when macro LINK_RX_ERR_CNT_EN is defined, implement err_count as specified in REQ-013 and REQ-026.
REQ-031 SHALL, when LINK_RX_ERR_CNT_EN is undefined, tie err_count to 0, omit its register, and leave all other behaviour, including credit return for errored words, unchanged.

Verification
REQ-032 SHALL cover this case: DEPTH=4, good words 0xA1, 0xA2, 0xA3 on consecutive edges with out_ready=1 -> out_data 0xA1, 0xA2, 0xA3 in cycles N+1..N+3, and credit_ret=1 in cycles N+2..N+4.
REQ-033 SHALL cover this case: out_ready=0, 5 good words 0x10..0x14 -> first 4 buffered, overflow=1 after the 5th edge, credit_ret stays 0; then out_ready=1 -> 0x10..0x13 delivered and 0x14 absent.
REQ-034 SHALL cover this case: FIFO full (4 entries), good word 0x55 with a simultaneous pop -> overflow stays 0 and 0x55 is delivered after the 3 remaining older words.
REQ-035 SHALL cover this case: an errored word and a pop on the same edge -> credit_ret=2 next cycle, err_count increments by 1, and the errored payload is never seen on out_data.
REQ-036 SHALL cover this case: 300 errored words with the macro defined -> err_count=255; with the macro undefined -> err_count=0 and 300 credits returned in total.
REQ-037 SHALL cover this case: rst_n driven low between clock edges with 3 words buffered -> out_valid=0 and overflow=0 immediately, and after release the FIFO is empty.
